// File: rtl/nachi_mem_pkg.sv
// Shared memory-path types: access sizes, store FSM states, word geometry.
// Latency: n/a (types and a pure helper function only).
// Backpressure: n/a.
package nachi_mem_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2,
        SZ_ILL  = 2'd3
    } mem_size_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BEAT0 = 2'd1,
        BEAT1 = 2'd2
    } store_state_e;

    localparam int WORD_BYTES = 4;

    // True when the access crosses a word boundary and needs two beats.
    // A halfword at offset 1 still fits inside one word (lanes 1..2).
    function automatic logic is_misaligned(input mem_size_e size, input logic [1:0] off);
        case (size)
            SZ_HALF: return off == 2'd3;
            SZ_WORD: return off != 2'd0;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/store_lane_align.sv
// Steers a narrow store operand onto word byte lanes and builds byte enables.
// Latency: purely combinational.
// Backpressure: none; the caller holds inputs stable.
// Ports: size/off/data describe the store, beat selects first (0) or second (1)
//        beat of a split; be/wdata are the lane-steered outputs, split flags a
//        word-crossing access.
module store_lane_align
    import nachi_mem_pkg::*;
(
    input  mem_size_e   size,
    input  logic [1:0]  off,
    input  logic [31:0] data,
    input  logic        beat,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic        split
);

    logic [3:0] mask;
    logic [7:0] be_wide;
    logic [4:0] sh0;
    logic [5:0] sh1;

    always_comb begin
        mask = 4'b0000;
        case (size)
            SZ_BYTE: mask = 4'b0001;
            SZ_HALF: mask = 4'b0011;
            SZ_WORD: mask = 4'b1111;
            default: mask = 4'b0000;
        endcase

        // Shifting into an 8-lane window: low nibble is beat0, high nibble
        // holds whatever spilled into the next word (beat1).
        be_wide = {4'b0000, mask} << off;
        sh0     = {off, 3'b000};
        sh1     = 6'd32 - {1'b0, off, 3'b000};
        split   = is_misaligned(size, off);

        if (beat) begin
            be    = be_wide[7:4];
            wdata = data >> sh1;
        end else begin
            be = be_wide[3:0];
            case (size)
                SZ_BYTE: wdata = {4{data[7:0]}};
                // Offsets 0/2 replicate; offsets 1/3 need a true shift.
                SZ_HALF: wdata = off[0] ? (data << sh0) : {2{data[15:0]}};
                default: wdata = data << sh0;
            endcase
        end
    end

endmodule

// File: rtl/store_narrow_unit.sv
// Narrows a register store to byte/half/word and writes it to word-aligned memory.
// Latency: accept at N -> first beat valid at N+1; done at N+2 (one beat) or N+3 (split).
// Backpressure: beats hold on mem_ready low; req_ready is high only in IDLE.
// Ports: req_* store request (valid/ready), mem_* write beat (valid/ready),
//        done/err single-cycle completion pulses.
// Build option: STORE_MISALIGN_SPLIT_EN splits word-crossing stores into two
//        beats; without it such stores are rejected with err.
module store_narrow_unit
    import nachi_mem_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int BEAT_TIMEOUT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_data,
    input  logic [1:0]        req_size,
    output logic              mem_valid,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_be,
    output logic              done,
    output logic              err
);

    localparam int TO_W    = (BEAT_TIMEOUT > 1) ? $clog2(BEAT_TIMEOUT) : 1;
    localparam int TO_LAST = (BEAT_TIMEOUT > 0) ? BEAT_TIMEOUT - 1 : 0;

    store_state_e state;
    mem_size_e    size_q;
    logic [1:0]   off_q;
    logic [31:0]  data_q;
    logic [TO_W-1:0] wait_cnt;
`ifdef STORE_MISALIGN_SPLIT_EN
    logic         split_q;
`endif

    mem_size_e    al_size;
    logic [1:0]   al_off;
    logic [31:0]  al_data;
    logic         al_beat;
    logic [3:0]   al_be;
    logic [31:0]  al_wdata;
    logic         al_split;
    logic         acc_legal;
    logic         timeout_hit;

    assign req_ready = (state == IDLE);

    // In IDLE the aligner looks at the incoming request (beat0); afterwards it
    // looks at the captured request to produce beat1.
    assign al_size = (state == IDLE) ? mem_size_e'(req_size) : size_q;
    assign al_off  = (state == IDLE) ? req_addr[1:0]          : off_q;
    assign al_data = (state == IDLE) ? req_data               : data_q;
    assign al_beat = (state != IDLE);

    store_lane_align u_align (
        .size  (al_size),
        .off   (al_off),
        .data  (al_data),
        .beat  (al_beat),
        .be    (al_be),
        .wdata (al_wdata),
        .split (al_split)
    );

`ifdef STORE_MISALIGN_SPLIT_EN
    assign acc_legal = (al_size != SZ_ILL);
`else
    assign acc_legal = (al_size != SZ_ILL) && !al_split;
`endif

    assign timeout_hit = (BEAT_TIMEOUT != 0) && (wait_cnt == TO_W'(TO_LAST));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            mem_valid <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            done      <= 1'b0;
            err       <= 1'b0;
            size_q    <= SZ_BYTE;
            off_q     <= '0;
            data_q    <= '0;
            wait_cnt  <= '0;
`ifdef STORE_MISALIGN_SPLIT_EN
            split_q   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    wait_cnt <= '0;
                    if (req_valid) begin
                        if (acc_legal) begin
                            state     <= BEAT0;
                            mem_valid <= 1'b1;
                            mem_addr  <= {req_addr[ADDR_W-1:2], 2'b00};
                            mem_be    <= al_be;
                            mem_wdata <= al_wdata;
                            size_q    <= al_size;
                            off_q     <= req_addr[1:0];
                            data_q    <= req_data;
`ifdef STORE_MISALIGN_SPLIT_EN
                            split_q   <= al_split;
`endif
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                BEAT0, BEAT1: begin
                    if (mem_ready) begin
                        wait_cnt <= '0;
`ifdef STORE_MISALIGN_SPLIT_EN
                        if (state == BEAT0 && split_q) begin
                            state     <= BEAT1;
                            mem_addr  <= mem_addr + ADDR_W'(WORD_BYTES);
                            mem_be    <= al_be;
                            mem_wdata <= al_wdata;
                        end else begin
                            state     <= IDLE;
                            mem_valid <= 1'b0;
                            done      <= 1'b1;
                        end
`else
                        state     <= IDLE;
                        mem_valid <= 1'b0;
                        done      <= 1'b1;
`endif
                    end else if (timeout_hit) begin
                        state     <= IDLE;
                        mem_valid <= 1'b0;
                        err       <= 1'b1;
                        wait_cnt  <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + TO_W'(1);
                    end
                end
                default: begin
                    state     <= IDLE;
                    mem_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_store_narrow_unit.sv
// Bench for store_narrow_unit: directed cases plus randomized stores with stalls,
// checked against a byte-by-byte placement model. A second instance with
// BEAT_TIMEOUT = 4 covers the timeout path.
module tb_store_narrow_unit;

`ifdef STORE_MISALIGN_SPLIT_EN
    localparam bit SPLIT = 1'b1;
`else
    localparam bit SPLIT = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready;
    logic [31:0] req_addr, req_data;
    logic [1:0]  req_size;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_be;
    logic        done, err;

    logic        t_req_valid, t_req_ready;
    logic [31:0] t_req_addr, t_req_data;
    logic [1:0]  t_req_size;
    logic        t_mem_valid, t_mem_ready;
    logic [31:0] t_mem_addr, t_mem_wdata;
    logic [3:0]  t_mem_be;
    logic        t_done, t_err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    store_narrow_unit #(.ADDR_W(32), .BEAT_TIMEOUT(0)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_data(req_data), .req_size(req_size),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_be(mem_be), .done(done), .err(err)
    );

    store_narrow_unit #(.ADDR_W(32), .BEAT_TIMEOUT(4)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .req_valid(t_req_valid), .req_ready(t_req_ready), .req_addr(t_req_addr),
        .req_data(t_req_data), .req_size(t_req_size),
        .mem_valid(t_mem_valid), .mem_ready(t_mem_ready), .mem_addr(t_mem_addr),
        .mem_wdata(t_mem_wdata), .mem_be(t_mem_be), .done(t_done), .err(t_err)
    );

    typedef struct packed {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
    } beat_t;

    beat_t exp_q[$];
    bit    exp_err;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] be2mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 4; i++)
            if (be[i]) m[8*i +: 8] = 8'hFF;
        return m;
    endfunction

    // Places each operand byte at its absolute address; bytes landing past
    // the first word go to the next word (address + 4, wrapping at 2^32).
    task automatic model(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        int    off, nb, pos;
        beat_t e0, e1;
        exp_q.delete();
        exp_err = 1'b0;
        nb = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : (sz == 2'd2) ? 4 : 0;
        if (nb == 0) begin
            exp_err = 1'b1;
            return;
        end
        off = int'(a[1:0]);
        if (off + nb > 4 && !SPLIT) begin
            exp_err = 1'b1;
            return;
        end
        e0.addr = a & 32'hFFFF_FFFC;
        e0.be = '0;
        e0.wdata = '0;
        e1.addr = e0.addr + 32'd4;
        e1.be = '0;
        e1.wdata = '0;
        for (int k = 0; k < nb; k++) begin
            pos = off + k;
            if (pos < 4) begin
                e0.be[pos] = 1'b1;
                e0.wdata[8*pos +: 8] = d[8*k +: 8];
            end else begin
                e1.be[pos-4] = 1'b1;
                e1.wdata[8*(pos-4) +: 8] = d[8*k +: 8];
            end
        end
        exp_q.push_back(e0);
        if (off + nb > 4) exp_q.push_back(e1);
    endtask

    // Issues one store at cycle N and follows it cycle by cycle. Each beat
    // stalls a random number of cycles in [st_lo, st_hi]. When full is set,
    // wdata is compared on all lanes against fw0/fw1, else on enabled lanes.
    task automatic run_store(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz,
                             input int st_lo, input int st_hi,
                             input bit full, input logic [31:0] fw0, input logic [31:0] fw1);
        int          stalls;
        logic [31:0] m, ew;
        model(a, d, sz);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = sz;
        mem_ready = 1'b0;
        step();
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_data  = $urandom;
        req_size  = 2'($urandom);
        chk("done_low_n1", done, 0);
        if (exp_err) begin
            chk("err_n1", err, 1);
            chk("no_mem_valid_n1", mem_valid, 0);
            chk("req_ready_n1", req_ready, 1);
            step();
            chk("err_once", err, 0);
            chk("no_mem_valid_n2", mem_valid, 0);
            chk("no_done_err", done, 0);
            return;
        end
        for (int b = 0; b < exp_q.size(); b++) begin
            stalls = $urandom_range(st_hi, st_lo);
            for (int s = 0; s <= stalls; s++) begin
                m  = full ? 32'hFFFF_FFFF : be2mask(exp_q[b].be);
                ew = full ? ((b == 0) ? fw0 : fw1) : exp_q[b].wdata;
                chk("mem_valid", mem_valid, 1);
                chk("mem_addr", mem_addr, exp_q[b].addr);
                chk("mem_be", 32'(mem_be), 32'(exp_q[b].be));
                chk("mem_wdata", mem_wdata & m, ew & m);
                chk("busy_no_done", done, 0);
                chk("busy_no_err", err, 0);
                chk("busy_not_ready", req_ready, 0);
                mem_ready = (s == stalls);
                step();
            end
            mem_ready = 1'b0;
        end
        chk("done_pulse", done, 1);
        chk("done_no_err", err, 0);
        chk("done_mem_valid_low", mem_valid, 0);
        chk("done_req_ready", req_ready, 1);
    endtask

    task automatic reset_mid_op();
        run_quiet_start(32'h0000_0200, 32'hCAFE_F00D, 2'd2);
        chk("rst_beat0_valid", mem_valid, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_valid_drop", mem_valid, 0);
        chk("rst_async_req_ready", req_ready, 1);
        step();
        step();
        rst_n = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("rst_no_done", done, 0);
            chk("rst_no_err", err, 0);
            chk("rst_no_valid", mem_valid, 0);
        end
        mem_ready = 1'b0;
    endtask

    task automatic run_quiet_start(input logic [31:0] a, input logic [31:0] d, input logic [1:0] sz);
        req_valid = 1'b1;
        req_addr  = a;
        req_data  = d;
        req_size  = sz;
        mem_ready = 1'b0;
        step();
        req_valid = 1'b0;
    endtask

    task automatic timeout_test();
        chk("to_req_ready", t_req_ready, 1);
        t_req_valid = 1'b1;
        t_req_addr  = 32'h0000_0040;
        t_req_data  = 32'h5566_7788;
        t_req_size  = 2'd2;
        step();
        t_req_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("to_wait_valid", t_mem_valid, 1);
            chk("to_wait_addr", t_mem_addr, 32'h0000_0040);
            chk("to_wait_no_err", t_err, 0);
            step();
        end
        chk("to_err_pulse", t_err, 1);
        chk("to_valid_drop", t_mem_valid, 0);
        chk("to_no_done", t_done, 0);
        chk("to_req_ready_back", t_req_ready, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("to_after_no_done", t_done, 0);
            chk("to_after_no_err", t_err, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_data = '0; req_size = '0; mem_ready = 1'b0;
        t_req_valid = 1'b0; t_req_addr = '0; t_req_data = '0; t_req_size = '0; t_mem_ready = 1'b0;
        step();
        step();
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_mem_be", 32'(mem_be), 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        rst_n = 1'b1;
        step();

        run_store(32'h0000_1002, 32'hDEAD_BEEF, 2'd0, 0, 0, 1'b1, 32'hEFEF_EFEF, 32'h0);
        run_store(32'h0000_0006, 32'h1234_ABCD, 2'd1, 0, 0, 1'b1, 32'hABCD_ABCD, 32'h0);
        run_store(32'h0000_0101, 32'h1122_3344, 2'd2, 0, 0, 1'b1, 32'h2233_4400, 32'h0000_0011);
        run_store(32'h0000_0100, 32'h1122_3344, 2'd3, 0, 0, 1'b0, 32'h0, 32'h0);
        run_store(32'h0000_0300, 32'h0BAD_F00D, 2'd2, 5, 5, 1'b1, 32'h0BAD_F00D, 32'h0);
        run_store(32'hFFFF_FFFE, 32'hA1B2_C3D4, 2'd2, 0, 0, 1'b0, 32'h0, 32'h0);
        reset_mid_op();
        timeout_test();

        for (int i = 0; i < 200; i++)
            run_store($urandom, $urandom, 2'($urandom), 0, 3, 1'b0, 32'h0, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
